// File: rtl/imem_loader_pkg.sv
// Shared constants for the instruction-memory loader: state codes, stream
// framing sizes and the word-address helper.
package imem_loader_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_LEN_LO  = 3'd1;
   localparam state_t ST_LEN_HI  = 3'd2;
   localparam state_t ST_COLLECT = 3'd3;
   localparam state_t ST_WRITE   = 3'd4;
   localparam state_t ST_DONE    = 3'd5;
   localparam state_t ST_ERR     = 3'd6;

   localparam int LEN_BYTES  = 2;
   localparam int WORD_BYTES = 4;
   localparam int LEN_BITS   = LEN_BYTES * 8;
   localparam int WORD_BITS  = WORD_BYTES * 8;

   // Byte address of word idx; wraps modulo 2^32.
   function automatic logic [31:0] word_addr(input logic [31:0] base,
                                             input logic [LEN_BITS-1:0] idx);
      return base + {14'd0, idx, 2'b00};
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream, control and instruction-memory write signals of the loader.
// master = host/stream side, slave = the loader itself.
interface imem_loader_if;
   logic        start;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        cpu_rst;
   logic        done;
   logic        err;

   modport master (
      output start, rx_data, rx_valid,
      input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, err
   );

   modport slave (
      input  start, rx_data, rx_valid,
      output rx_ready, imem_we, imem_addr, imem_wdata, cpu_rst, done, err
   );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed byte stream and writes it word by
// word into external instruction memory, holding the core in reset until done.
//
// state   | meaning
// IDLE    | waiting for start after reset
// LEN_LO  | receiving length byte 0
// LEN_HI  | receiving length byte 1, range-check length
// COLLECT | assembling the current word, byte by byte
// WRITE   | one-cycle write strobe of the assembled word
// DONE    | program loaded, core released
// ERR     | illegal length, core held in reset
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned   MAX_WORDS = 1024,
   parameter logic [31:0]   BASE_ADDR = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   imem_loader_if.slave    bus
);

   state_t                 state_q, state_d;
   logic [LEN_BITS-1:0]    len_q, len_d;
   logic [LEN_BITS-1:0]    idx_q, idx_d;
   logic [1:0]             bcnt_q, bcnt_d;
   logic [23:0]            word_q, word_d;
   logic [31:0]            addr_q, addr_d;
   logic [WORD_BITS-1:0]   wdata_q, wdata_d;

   logic                   rx_ready;
   logic                   xfer;
   logic [LEN_BITS-1:0]    len_new;
   logic [LEN_BITS-1:0]    idx_inc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
         idx_q   <= '0;
         bcnt_q  <= '0;
         word_q  <= '0;
         addr_q  <= BASE_ADDR;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         bcnt_q  <= bcnt_d;
         word_q  <= word_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      idx_d   = idx_q;
      bcnt_d  = bcnt_q;
      word_d  = word_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      xfer    = bus.rx_valid && rx_ready;
      len_new = {bus.rx_data, len_q[7:0]};
      idx_inc = idx_q + 16'd1;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) state_d = ST_LEN_LO;
         end
         ST_LEN_LO: begin
            if (xfer) begin
               len_d[7:0] = bus.rx_data;
               state_d    = ST_LEN_HI;
            end
         end
         ST_LEN_HI: begin
            if (xfer) begin
               len_d = len_new;
               if (len_new == '0 || {16'd0, len_new} > 32'(MAX_WORDS)) begin
                  state_d = ST_ERR;
               end else begin
                  idx_d   = '0;
                  bcnt_d  = '0;
                  state_d = ST_COLLECT;
               end
            end
         end
         ST_COLLECT: begin
            if (xfer) begin
               bcnt_d = bcnt_q + 2'd1;
               case (bcnt_q)
                  2'd0: word_d[7:0]   = bus.rx_data;
                  2'd1: word_d[15:8]  = bus.rx_data;
                  2'd2: word_d[23:16] = bus.rx_data;
                  default: ;
               endcase
               // Last lane goes straight into the write register so the
               // strobe can fire on the very next cycle.
               if (bcnt_q == 2'(WORD_BYTES - 1)) begin
                  wdata_d = {bus.rx_data, word_q};
                  addr_d  = word_addr(BASE_ADDR, idx_q);
                  state_d = ST_WRITE;
               end
            end
         end
         ST_WRITE: begin
            idx_d   = idx_inc;
            state_d = (idx_inc == len_q) ? ST_DONE : ST_COLLECT;
         end
         ST_DONE, ST_ERR: begin
            if (bus.start) state_d = ST_LEN_LO;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rx_ready = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                 (state_q == ST_COLLECT);
      bus.rx_ready   = rx_ready;
      bus.imem_we    = (state_q == ST_WRITE);
      bus.imem_addr  = addr_q;
      bus.imem_wdata = wdata_q;
      bus.done       = (state_q == ST_DONE);
      bus.err        = (state_q == ST_ERR);
      bus.cpu_rst    = (state_q != ST_DONE);
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader: two instances (default and offset base /
// small MAX_WORDS) checked against a list-of-writes reference model.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel;
   logic        start_s;
   logic        valid_s;
   logic [7:0]  data_s;

   int n_checks = 0;
   int n_pass   = 0;
   int gap_at   = -1;
   int gap_len  = 0;

   logic [31:0] wbuf [0:1023];
   logic [31:0] got_a [$];
   logic [31:0] got_d [$];

   always #5 clk = ~clk;

   imem_loader_if if0 ();
   imem_loader_if if1 ();

   assign if0.start    = start_s & ~sel;
   assign if0.rx_valid = valid_s & ~sel;
   assign if0.rx_data  = data_s;
   assign if1.start    = start_s & sel;
   assign if1.rx_valid = valid_s & sel;
   assign if1.rx_data  = data_s;

   imem_loader #(.MAX_WORDS(1024), .BASE_ADDR(32'h0000_0000)) dut0 (
      .clk (clk), .rst (rst), .bus (if0)
   );
   imem_loader #(.MAX_WORDS(8), .BASE_ADDR(32'h0000_1000)) dut1 (
      .clk (clk), .rst (rst), .bus (if1)
   );

   wire        ready_o   = sel ? if1.rx_ready   : if0.rx_ready;
   wire        we_o      = sel ? if1.imem_we    : if0.imem_we;
   wire [31:0] addr_o    = sel ? if1.imem_addr  : if0.imem_addr;
   wire [31:0] data_o    = sel ? if1.imem_wdata : if0.imem_wdata;
   wire        done_o    = sel ? if1.done       : if0.done;
   wire        err_o     = sel ? if1.err        : if0.err;
   wire        cpu_rst_o = sel ? if1.cpu_rst    : if0.cpu_rst;
   wire [31:0] cur_base  = sel ? 32'h0000_1000  : 32'h0000_0000;
   wire [31:0] cur_max   = sel ? 32'd8          : 32'd1024;

   always @(negedge clk) begin
      if (we_o === 1'b1) begin
         got_a.push_back(addr_o);
         got_d.push_back(data_o);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
      int n = 0;
      valid_s = 1'b0;
      repeat (gap) step();
      valid_s = 1'b1;
      data_s  = b;
      start_s = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      while (!ready_o && n < 20) begin
         step();
         n++;
      end
      if (!ready_o) check("ready_timeout", 32'd0, 32'd1);
      else step();
      valid_s = 1'b0;
      start_s = 1'b0;
   endtask

   task automatic pulse_start();
      start_s = 1'b1;
      step();
      start_s = 1'b0;
   endtask

   // Reference: a legal load of len words writes wbuf[i] at base+4*i, in order.
   task automatic run_load(input int len, input int gapmax, input bit noise);
      logic [31:0] w;
      logic [31:0] lenv;
      int nmis;
      got_a.delete();
      got_d.delete();
      lenv = 32'(len);
      pulse_start();
      check("len_lo_ready", 32'(ready_o), 32'd1);
      send_byte(lenv[7:0], 0, noise);
      send_byte(lenv[15:8], 0, noise);
      if (len < 1 || lenv > cur_max) begin
         check("err_flag", 32'(err_o), 32'd1);
         check("err_cpu_rst", 32'(cpu_rst_o), 32'd1);
         check("err_ready", 32'(ready_o), 32'd0);
         check("err_done", 32'(done_o), 32'd0);
         valid_s = 1'b1;
         data_s  = 8'h5A;
         repeat (3) step();
         valid_s = 1'b0;
         check("err_hold", 32'(err_o), 32'd1);
         check("err_nowrite", 32'(got_a.size()), 32'd0);
      end else begin
         for (int i = 0; i < len; i++) begin
            w = wbuf[i];
            for (int b = 0; b < 4; b++) begin
               send_byte(w[8*b +: 8],
                         (i == 0 && b == gap_at) ? gap_len : int'($urandom_range(0, gapmax)),
                         noise);
            end
            check("we_latency", 32'(we_o), 32'd1);
            check("waddr", addr_o, cur_base + 32'(4 * i));
            check("wdata", data_o, w);
         end
         step();
         check("done_flag", 32'(done_o), 32'd1);
         check("done_cpu_rst", 32'(cpu_rst_o), 32'd0);
         check("done_err", 32'(err_o), 32'd0);
         check("done_we", 32'(we_o), 32'd0);
         check("nwrites", 32'(got_a.size()), 32'(len));
         nmis = 0;
         for (int i = 0; i < len && i < got_a.size(); i++)
            if (got_a[i] !== cur_base + 32'(4 * i) || got_d[i] !== wbuf[i]) nmis++;
         check("write_log", 32'(nmis), 32'd0);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_ready"}, 32'(ready_o), 32'd0);
      check({tag, "_we"}, 32'(we_o), 32'd0);
      check({tag, "_done"}, 32'(done_o), 32'd0);
      check({tag, "_err"}, 32'(err_o), 32'd0);
      check({tag, "_cpu_rst"}, 32'(cpu_rst_o), 32'd1);
      check({tag, "_addr"}, addr_o, cur_base);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int len;
      rst = 1'b1; sel = 1'b0; start_s = 1'b0; valid_s = 1'b0; data_s = 8'h00;
      repeat (2) step();
      check_reset_state("rst0");
      check("rst0_wdata", data_o, 32'd0);
      sel = 1'b1;
      #1;
      check_reset_state("rst1");
      check("rst1_wdata", data_o, 32'd0);
      sel = 1'b0;
      rst = 1'b0;
      step();

      // Two-instruction program, stream without gaps.
      wbuf[0] = 32'h0000_0013;
      wbuf[1] = 32'h0010_0093;
      run_load(2, 0, 1'b0);

      run_load(0, 0, 1'b0);
      run_load(1025, 0, 1'b0);
      wbuf[0] = 32'h0000_0073;
      run_load(1, 0, 1'b0);

      // Stalled stream in the middle of a word.
      gap_at = 2; gap_len = 5;
      wbuf[0] = 32'hDEAD_BEEF;
      wbuf[1] = 32'h1234_5678;
      run_load(2, 0, 1'b0);
      gap_at = -1;

      // Reset after two bytes of word 1; reset also beats a pending transfer.
      wbuf[0] = 32'hA1B2_C3D4;
      got_a.delete();
      got_d.delete();
      pulse_start();
      send_byte(8'd2, 0, 1'b0);
      send_byte(8'd0, 0, 1'b0);
      for (int b = 0; b < 4; b++) send_byte(wbuf[0][8*b +: 8], 0, 1'b0);
      send_byte(8'h11, 0, 1'b0);
      send_byte(8'h22, 0, 1'b0);
      valid_s = 1'b1; data_s = 8'h33; start_s = 1'b1; rst = 1'b1;
      step();
      valid_s = 1'b0; start_s = 1'b0; rst = 1'b0;
      check_reset_state("midrst");
      check("midrst_nwrites", 32'(got_a.size()), 32'd1);
      for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
      run_load(3, 1, 1'b0);

      // Offset base address, start noise during the load, MAX_WORDS boundary.
      sel = 1'b1;
      step();
      for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
      run_load(3, 1, 1'b1);
      run_load(8, 0, 1'b1);
      run_load(9, 0, 1'b0);

      for (int k = 0; k < 12; k++) begin
         sel = 1'($urandom_range(0, 1));
         step();
         if ($urandom_range(0, 4) == 0)
            len = ($urandom_range(0, 1) == 0) ? 0 : int'(cur_max) + 1 + int'($urandom_range(0, 100));
         else
            len = int'($urandom_range(1, 6));
         for (int i = 0; i < 6; i++) wbuf[i] = $urandom;
         run_load(len, 2, 1'b1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter MAX_WORDS, default 1024, largest program length accepted, in 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, byte address of the first instruction word written.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle pulse that begins a load.
REQ-006 rx_data  input  8  incoming byte.
REQ-007 rx_valid  input  1  rx_data is valid this cycle.
REQ-008 rx_ready  output  1  loader accepts a byte this cycle.
REQ-009 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 imem_addr  output  32  byte address of the word being written.
REQ-011 imem_wdata  output  32  instruction word being written.
REQ-012 cpu_rst  output  1  holds the single-cycle core in reset while no valid program is loaded.
REQ-013 done  output  1  load completed successfully.
REQ-014 err  output  1  load aborted on an illegal length.

Function
REQ-015 Stream format: length (16 bits, low byte first), then length words of 4 bytes each, least-significant byte first (first byte -> imem_wdata[7:0]).
REQ-016 Byte transfer occurs only in a cycle with rx_valid=1 and rx_ready=1; any rx_valid gap stalls the FSM indefinitely, with no timeout.
REQ-017 FSM states: IDLE, LEN_LO, LEN_HI, COLLECT, WRITE, DONE, ERR.
REQ-018 IDLE: start=1 -> LEN_LO; otherwise stay.
REQ-019 LEN_LO: on transfer, latch length[7:0] -> LEN_HI.
REQ-020 LEN_HI: on transfer, latch length[15:8]; final length 0 or > MAX_WORDS -> ERR, else COLLECT with word index 0 and byte counter 0.
REQ-021 COLLECT: each transfer shifts the byte into its lane and increments the 2-bit byte counter; the transfer of byte 3 -> WRITE.
REQ-022 WRITE (exactly one cycle): imem_we=1, imem_addr=BASE_ADDR+4*word index, imem_wdata=assembled word; then increment word index; if the new index equals length -> DONE, else COLLECT.
REQ-023 Latency: imem_we is asserted in the cycle after the 4th byte of a word is transferred.
REQ-024 rx_ready=1 only in LEN_LO, LEN_HI and COLLECT; it is 0 in IDLE, WRITE, DONE and ERR, so bytes presented then are not consumed.
REQ-025 imem_we=0 in all states other than WRITE; imem_addr and imem_wdata hold their last values outside WRITE.
REQ-026 cpu_rst=0 only in DONE; done=1 only in DONE; err=1 only in ERR.
REQ-027 DONE and ERR: start=1 -> LEN_LO (reload; done/err and cpu_rst update the same edge); otherwise stay.
REQ-028 start is ignored in LEN_LO, LEN_HI, COLLECT and WRITE.
REQ-029 Word index is 16 bits; imem_addr arithmetic is 32-bit modulo 2^32.

Reset
REQ-030 rst=1 at a clock edge forces IDLE, byte counter 0, word index 0, length 0, imem_addr=BASE_ADDR, imem_wdata=0; outputs are imem_we=0, rx_ready=0, done=0, err=0 and cpu_rst=1.
REQ-031 rst has priority over start and over any transfer in the same cycle; a reset mid-load discards the partial word, and words already written remain in memory.

Structure
REQ-032 State encoding (3-bit localparams) and the stream-format constants (length byte count 2, bytes per word 4) belong in the shared package or header used by the core.
REQ-033 Single flat module, no sub-modules; the memory itself is external and is written through imem_we/imem_addr/imem_wdata.

Verification
REQ-034 Scenario: start, bytes 02 00, then 13 00 00 00 and 93 00 10 00 with rx_valid held high -> two imem_we pulses (addr 0x0 data 0x00000013, addr 0x4 data 0x00100093); then done=1 and cpu_rst=0.
REQ-035 Scenario: length bytes 00 00 -> err=1, cpu_rst=1, rx_ready=0, and no imem_we.
REQ-036 Scenario: length 1025 (01 04) with MAX_WORDS=1024 -> err=1 with no write; then start with length 1 and word 0x00000073 -> write at addr 0x0, done=1.
REQ-037 Scenario: rx_valid deasserted for 5 cycles between bytes 2 and 3 of a word -> no extra transfer and no write during the gap; the word is written correctly one cycle after byte 3 is transferred.
REQ-038 Scenario: rst asserted after 2 of 4 bytes of word 1 -> next cycle IDLE, cpu_rst=1, done=0; a fresh start and full load writes from BASE_ADDR again.
REQ-039 Scenario: BASE_ADDR=32'h0000_1000, length 3 -> writes at 0x1000, 0x1004, 0x1008; start pulses during the load are ignored.
